// File: rtl/delay_line_reader.sv
// Per-transducer delay line: returns the drive word written DELAY updates ago, flagged valid only when enough history exists.
// Optional build macro DELAY_LINE_ZERO_FILL_EN: invalid results and SYNC force data_out to zero instead of holding.
module delay_line_reader #(
  parameter int DEPTH_W = 7,
  parameter int DATA_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               update,
  input  logic               sync,
  input  logic [DEPTH_W-1:0] delay,
  input  logic [DATA_W-1:0]  data_in,
  output logic [DATA_W-1:0]  data_out,
  output logic               data_valid
);

  localparam int DEPTH = 1 << DEPTH_W;
  localparam logic [DEPTH_W-1:0] FILL_MAX = '1;
`ifdef DELAY_LINE_ZERO_FILL_EN
  localparam bit ZERO_FILL = 1'b1;
`else
  localparam bit ZERO_FILL = 1'b0;
`endif

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [DEPTH_W-1:0] w;
  logic [DEPTH_W-1:0] fill;
  logic [DEPTH_W-1:0] w_eff;
  logic [DEPTH_W-1:0] fill_eff;
  logic [DEPTH_W-1:0] rd_addr;
  logic [DATA_W-1:0]  rd_data;
  logic [DATA_W-1:0]  out_next;
  logic [DATA_W-1:0]  out_p1;
  logic               vld_p1;
  logic               hit;

  function automatic logic [DEPTH_W-1:0] sat_inc(input logic [DEPTH_W-1:0] f);
    return (f == FILL_MAX) ? f : f + 1'b1;
  endfunction

  // A coincident SYNC restarts history before this update is evaluated.
  always_comb begin
    w_eff    = sync ? '0 : w;
    fill_eff = sync ? '0 : fill;
    rd_addr  = w_eff - delay;
    rd_data  = (delay == '0) ? data_in : mem[rd_addr];
    hit      = (fill_eff >= delay);
    out_next = hit ? rd_data : (ZERO_FILL ? '0 : out_p1);
  end

  always_ff @(posedge clk) begin
    if (update) begin
      mem[w_eff] <= data_in;
    end
  end

  // Stage p1: registered delayed word and its validity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w      <= '0;
      fill   <= '0;
      out_p1 <= '0;
      vld_p1 <= 1'b0;
    end else if (update) begin
      w      <= w_eff + 1'b1;
      fill   <= sat_inc(fill_eff);
      out_p1 <= out_next;
      vld_p1 <= hit;
    end else if (sync) begin
      w      <= '0;
      fill   <= '0;
      vld_p1 <= 1'b0;
      if (ZERO_FILL) begin
        out_p1 <= '0;
      end
    end
  end

  assign data_out   = out_p1;
  assign data_valid = vld_p1;

endmodule

// File: tb/tb_delay_line_reader.sv
// Scoreboard bench for delay_line_reader: directed updates push expected words, a monitor pops and compares.
module tb_delay_line_reader;

  localparam int DEPTH_W = 7;
  localparam int DATA_W  = 16;
`ifdef DELAY_LINE_ZERO_FILL_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic               clk;
  logic               rst_n;
  logic               update;
  logic               sync;
  logic [DEPTH_W-1:0] delay;
  logic [DATA_W-1:0]  data_in;
  logic [DATA_W-1:0]  data_out;
  logic               data_valid;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              valid;
    string             tag;
  } exp_t;

  exp_t              sb[$];
  logic [DATA_W-1:0] last_exp;
  int                n_checks = 0;
  int                n_fail   = 0;

  delay_line_reader #(.DEPTH_W(DEPTH_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .update     (update),
    .sync       (sync),
    .delay      (delay),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_valid (data_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every edge that samples UPDATE or SYNC yields one expected result.
  always begin : monitor
    exp_t e;
    @(posedge clk);
    if (rst_n && (update || sync)) begin
      #1;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_underflow: got output with no expectation at %0t", $time);
      end else begin
        e = sb.pop_front();
        check({e.tag, "_data"}, {16'h0, data_out}, {16'h0, e.data});
        check({e.tag, "_valid"}, {31'h0, data_valid}, {31'h0, e.valid});
      end
    end
  end

  task automatic upd(input logic [DEPTH_W-1:0] d, input logic [DATA_W-1:0] din, input logic s,
                     input logic ev, input logic [DATA_W-1:0] ed, input string tag);
    exp_t e;
    @(negedge clk);
    delay   = d;
    data_in = din;
    update  = 1'b1;
    sync    = s;
    e.valid = ev;
    e.data  = ev ? ed : (ZF ? 16'h0 : last_exp);
    e.tag   = tag;
    last_exp = e.data;
    sb.push_back(e);
    @(negedge clk);
    update  = 1'b0;
    sync    = 1'b0;
    delay   = 7'($urandom);
    data_in = 16'($urandom);
  endtask

  task automatic sync_only(input string tag);
    exp_t e;
    @(negedge clk);
    sync    = 1'b1;
    e.valid = 1'b0;
    e.data  = ZF ? 16'h0 : last_exp;
    e.tag   = tag;
    last_exp = e.data;
    sb.push_back(e);
    @(negedge clk);
    sync = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clk      = 1'b0;
    rst_n    = 1'b1;
    update   = 1'b0;
    sync     = 1'b0;
    delay    = '0;
    data_in  = '0;
    last_exp = '0;
    #1 rst_n = 1'b0;
    #20;
    check("reset_data", {16'h0, data_out}, 32'h0);
    check("reset_valid", {31'h0, data_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    upd(7'd0, 16'h1234, 1'b0, 1'b1, 16'h1234, "bypass");

    sync_only("sync_alone");
    upd(7'd3, 16'd1, 1'b0, 1'b0, 16'd0, "d3_u1");
    upd(7'd3, 16'd2, 1'b0, 1'b0, 16'd0, "d3_u2");
    upd(7'd3, 16'd3, 1'b0, 1'b0, 16'd0, "d3_u3");
    upd(7'd3, 16'd4, 1'b0, 1'b1, 16'd1, "d3_u4");
    upd(7'd3, 16'd5, 1'b0, 1'b1, 16'd2, "d3_u5");
    drain();

    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_data", {16'h0, data_out}, 32'h0);
    check("async_reset_valid", {31'h0, data_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    last_exp = '0;

    for (int k = 1; k <= 300; k++)
      upd(7'd127, 16'(k), 1'b0, (k >= 128), 16'(k - 127), "d127");

    for (int k = 301; k <= 310; k++)
      upd(7'd10, 16'(k), 1'b0, 1'b1, 16'(k - 10), "d10");
    for (int k = 311; k <= 320; k++)
      upd(7'd20, 16'(k), 1'b0, 1'b1, 16'(k - 20), "d20_increase");

    sync_only("sync_restart");
    for (int j = 1; j <= 25; j++)
      upd(7'd20, 16'(1000 + j), 1'b0, (j >= 21), 16'(1000 + j - 20), "d20_refill");
    upd(7'd5, 16'd1026, 1'b0, 1'b1, 16'd1021, "d5_decrease");

    upd(7'd0, 16'hBEEF, 1'b1, 1'b1, 16'hBEEF, "sync_upd_bypass");
    upd(7'd1, 16'h0001, 1'b0, 1'b1, 16'hBEEF, "after_sync_d1");
    upd(7'd2, 16'h0055, 1'b1, 1'b0, 16'h0000, "sync_upd_invalid");
    upd(7'd1, 16'h0066, 1'b0, 1'b1, 16'h0055, "after_sync_addr0");
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/delay_line_reader.md
Name: delay_line_reader

Overview:
- Read-side delay line for per-transducer 16-bit drive words (duty/phase).
- Upstream pushes one word per UPDATE strobe. The block returns the word written DELAY updates earlier, with an explicit validity flag.
- Uses an explicit write pointer and a fill counter, so it knows when history is insufficient: after reset, after SYNC, or when DELAY increases.
- Sits between the modulation/normal-operation data path and the PWM generator, one instance per transducer.

Parameters:
- DEPTH_W, 7, log2 of buffer depth (128 entries); DELAY range is 0..2^DEPTH_W-1.
- DATA_W, 16, word width.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- UPDATE  in  1  single-cycle strobe; one sample step.
- SYNC  in  1  single-cycle; restarts history (pointer and fill to 0).
- DELAY  in  DEPTH_W  requested delay in UPDATE steps; sampled only on UPDATE cycles.
- DATA_IN  in  DATA_W  sample written on UPDATE.
- DATA_OUT  out  DATA_W  delayed sample, registered.
- DATA_VALID  out  1  DATA_OUT holds genuine history for the current DELAY.

Behaviour:
- Reset (RST_N low, async):
  - w (write ptr) = 0, fill = 0, DATA_OUT = 0, DATA_VALID = 0.
  - Buffer RAM is not reset; contents are don't-care and are masked by fill.
- Storage: 2^DEPTH_W x DATA_W distributed RAM; one write port, one asynchronous read port.
- Idle cycle (UPDATE=0, SYNC=0): all state and outputs hold.
- UPDATE cycle, with d = DELAY, f = fill before update:
  - RAM[w] <= DATA_IN.
  - If d == 0: DATA_OUT <= DATA_IN (write-first bypass; RAM is not read).
  - If d > 0: DATA_OUT <= RAM[(w - d) mod 2^DEPTH_W]. Subtraction is DEPTH_W-bit and wraps.
  - DATA_VALID <= (f >= d).
  - w <= w + 1 (wraps 127 -> 0).
  - fill <= min(f + 1, 2^DEPTH_W - 1) (saturates at 127).
- Latency: DATA_OUT and DATA_VALID update on the clock edge that samples UPDATE, one cycle after DATA_IN is presented. They are constant between UPDATEs.
- Delay semantics:
  - With steady d and f >= d, the output on update n equals the input of update n-d.
  - Maximum d = 127 reads address w+1, written 127 updates earlier. No collision with the current write.
- DELAY increase:
  - DATA_VALID deasserts if f < new d. It re-asserts automatically once fill catches up.
  - Because fill saturates at 127, steady operation is always valid.
- DELAY decrease: output jumps to the newer sample; intermediate samples are skipped. DATA_VALID stays 1.
- SYNC alone (UPDATE=0): w <= 0, fill <= 0, DATA_VALID <= 0. DATA_OUT value per the optional feature.
- SYNC and UPDATE in the same cycle: SYNC wins for history.
  - Write to address 0; w <= 1; fill <= 1.
  - Output is evaluated with f = 0: valid only if d == 0, which gives the bypass.
- DATA_OUT when the UPDATE result is invalid: see Optional Feature.
- DELAY and DATA_IN are ignored on cycles without UPDATE.

Optional Feature:
- Macro DELAY_LINE_ZERO_FILL_EN.
- Defined: any UPDATE with f < d, and any SYNC, loads DATA_OUT <= 0, a safe zero-duty drive.
- Undefined: on those events DATA_OUT holds its previous value; only DATA_VALID drops.
- DATA_VALID behaviour is identical in both builds.

Test Plan:
- Reset then DELAY=0, UPDATE with DATA_IN=0x1234 -> next cycle DATA_OUT=0x1234, DATA_VALID=1.
- DELAY=3, updates with DATA_IN=1,2,3,4,5 -> VALID=0,0,0,1,1. Outputs on updates 4 and 5 are 1 and 2. Outputs 1..3 are 0 with ZERO_FILL, held with hold build.
- Steady DELAY=127 over 300 updates (DATA_IN=k) -> from update 128 onward DATA_OUT = k-127, VALID=1. Check pointer wrap at 127->0.
- After 200 updates, DELAY 10->20 -> VALID stays 1 (fill saturated at 127), output lags by 20. Then SYNC, DELAY=20 -> VALID=0 for 20 updates, then 1.
- SYNC coincident with UPDATE, DELAY=0, DATA_IN=0xBEEF -> DATA_OUT=0xBEEF, VALID=1. Next update with DELAY=1 returns 0xBEEF (address 0), VALID=1.
- Assert RST_N low mid-stream between clock edges -> outputs 0 immediately (async). After release, behaviour matches a fresh start.
